// File: rtl/ahb_sram_slave.sv
// AHB-Lite subordinate backed by a 32-bit-wide internal memory.
// Each legal transfer gets WAIT_STATES wait cycles and then an OKAY completion.
// Out-of-range or misaligned transfers get the two-cycle ERROR response and never touch memory.
module ahb_sram_slave #(
  parameter int MEM_AW      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET_n,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_READY, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        wait_cnt_reg, wait_cnt_next;
  logic              pend_valid_reg, pend_valid_next;
  logic              pend_write_reg, pend_write_next;
  logic [MEM_AW-1:0] addr_reg, addr_next;
  logic [1:0]        size_reg, size_next;
  logic [1:0]        lo_reg, lo_next;

  logic              phase_end;
  logic              sample;
  logic              legal;
  logic              commit;
  logic              load_read;
  logic [MEM_AW-1:0] sample_addr;
  logic [3:0]        lane_en;
  logic [31:0]       rd_data;

  // Burst type and the BUSY/SEQ distinction carry no information here: every
  // beat is decoded from its own address.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HTRANS[0]};

  assign sample      = HSEL & HREADYIN & HTRANS[1];
  assign sample_addr = HADDR[MEM_AW+1:2];
  assign legal       = ((HADDR >> (MEM_AW + 2)) == 32'd0) &&
                       (HSIZE <= 3'b010) &&
                       !((HSIZE == 3'b001) && HADDR[0]) &&
                       !((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));

  // A data phase finishes on any edge where HREADYOUT is high.
  assign phase_end = (state_reg == ST_READY) || (state_reg == ST_ERR2);
  assign commit    = (state_reg == ST_READY) & pend_valid_reg & pend_write_reg;
  assign load_read = phase_end & sample & legal & ~HWRITE;

  // Next-state, response outputs and pending-transfer bookkeeping.
  always_comb begin
    state_next      = state_reg;
    wait_cnt_next   = wait_cnt_reg;
    pend_valid_next = pend_valid_reg;
    pend_write_next = pend_write_reg;
    addr_next       = addr_reg;
    size_next       = size_reg;
    lo_next         = lo_reg;
    HREADYOUT       = 1'b1;
    HRESP           = 1'b0;

    case (state_reg)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt_reg == 4'd0) state_next = ST_READY;
        else                      wait_cnt_next = wait_cnt_reg - 4'd1;
      end
      ST_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 1'b1;
        state_next = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP = 1'b1;
      end
      default: ;
    endcase

    if (phase_end) begin
      state_next      = ST_READY;
      pend_valid_next = 1'b0;
      if (sample) begin
        if (!legal) begin
          state_next = ST_ERR1;
        end else begin
          pend_valid_next = 1'b1;
          pend_write_next = HWRITE;
          addr_next       = sample_addr;
          size_next       = HSIZE[1:0];
          lo_next         = HADDR[1:0];
          if (WAIT_STATES > 0) begin
            state_next    = ST_WAIT;
            wait_cnt_next = WAIT_LOAD;
          end
        end
      end
    end
  end

  // Control state register; reset drops any pending transfer.
  always_ff @(posedge HCLK or negedge HRESET_n) begin
    if (!HRESET_n) begin
      state_reg      <= ST_READY;
      wait_cnt_reg   <= 4'd0;
      pend_valid_reg <= 1'b0;
      pend_write_reg <= 1'b0;
      addr_reg       <= '0;
      size_reg       <= 2'd0;
      lo_reg         <= 2'd0;
    end else begin
      state_reg      <= state_next;
      wait_cnt_reg   <= wait_cnt_next;
      pend_valid_reg <= pend_valid_next;
      pend_write_reg <= pend_write_next;
      addr_reg       <= addr_next;
      size_reg       <= size_next;
      lo_reg         <= lo_next;
    end
  end

  // Little-endian byte lanes touched by the pending write.
  always_comb begin
    lane_en = 4'b0000;
    case (size_reg)
      2'd0:    lane_en[lo_reg] = 1'b1;
      2'd1:    lane_en = lo_reg[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [0:DEPTH-1];
      logic [7:0] rd_byte_reg;

      // Commit writes; capture read data on the sampling edge, forwarding a
      // write that lands on the same word in the same edge.
      always_ff @(posedge HCLK) begin
        if (commit && lane_en[gi]) mem[addr_reg] <= HWDATA[8*gi +: 8];
        if (load_read) begin
          if (commit && lane_en[gi] && (addr_reg == sample_addr))
            rd_byte_reg <= HWDATA[8*gi +: 8];
          else
            rd_byte_reg <= mem[sample_addr];
        end
      end

      assign rd_data[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  // Read data is only driven while a legal read data phase is in progress.
  assign HRDATA = (pend_valid_reg && !pend_write_reg) ? rd_data : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: a pipelined AHB-Lite driver pushes the
// expected response of every address phase; a monitor checks each data phase.
module tb_ahb_sram_slave;
  localparam int MEM_AW = 8;
  localparam int WS     = 2;
  localparam int NBYTES = 4 << MEM_AW;

  logic        HCLK = 1'b0;
  logic        HRESET_n;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADYIN;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  assign HREADYIN = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahb_sram_slave #(.MEM_AW(MEM_AW), .WAIT_STATES(WS)) dut (
    .HCLK(HCLK), .HRESET_n(HRESET_n), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA)
  );

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    bit          resp;
    int          waits;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          txn_no = 0;
  logic [7:0]  model [0:NBYTES-1];

  // ---------------- reference model ----------------
  function automatic bit legal_access(input logic [31:0] a, input logic [2:0] s);
    if (a >= 32'(NBYTES)) return 1'b0;
    if (s > 3'd2) return 1'b0;
    if ((a % (32'd1 << s)) != 32'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int w;
    w = int'(a & ~32'd3);
    return {model[w+3], model[w+2], model[w+1], model[w]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Wait for the edge that ends the current data phase, then step past it.
  task automatic wait_phase_end();
    int n;
    n = 0;
    @(negedge HCLK);
    while (HREADYOUT !== 1'b1) begin
      n++;
      if (n > 50) begin
        $display("FAIL hready_timeout: HREADYOUT low for %0d cycles, required at most %0d", n, WS + 1);
        $fatal(1, "bench stopped");
      end
      @(negedge HCLK);
    end
    @(posedge HCLK);
    #1;
  endtask

  // Present one address phase, wait for it to be taken, then drive its data
  // and record the expected data-phase response.
  task automatic issue(input string tag, input bit sel, input logic [1:0] trans, input bit wr,
                       input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   nb;
    int   base;
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HSIZE  = size;
    HADDR  = addr;
    HBURST = 3'($urandom_range(0, 7));
    wait_phase_end();
    HWDATA  = wdata;
    e.tag   = tag;
    e.rdata = 32'h0;
    e.resp  = 1'b0;
    e.waits = 0;
    if (sel && trans[1]) begin
      if (!legal_access(addr, size)) begin
        e.resp  = 1'b1;
        e.waits = 1;
      end else begin
        e.waits = WS;
        nb   = 1 << size;
        base = int'(addr) & ~(nb - 1);
        if (wr) begin
          for (int b = 0; b < nb; b++)
            model[base + b] = wdata[8*((base + b) % 4) +: 8];
        end else begin
          e.rdata = word_at(addr);
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // Assert reset in the first wait cycle of a word transfer.
  task automatic reset_mid(input string tag, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = wr;
    HSIZE  = 3'b010;
    HADDR  = addr;
    wait_phase_end();
    HWDATA = wdata;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    #2;
    check({tag, "_pre_hready"}, 32'(HREADYOUT), 32'd0);
    if (!wr) check({tag, "_pre_hrdata"}, HRDATA, word_at(addr));
    HRESET_n = 1'b0;
    #1;
    check({tag, "_rst_hready"}, 32'(HREADYOUT), 32'd1);
    check({tag, "_rst_hresp"},  32'(HRESP),     32'd0);
    check({tag, "_rst_hrdata"}, HRDATA,         32'h0);
    @(posedge HCLK);
    #1;
    HRESET_n = 1'b1;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      bit          sel;
      bit          wr;
      logic [1:0]  tr;
      logic [2:0]  sz;
      logic [31:0] a;
      sel = ($urandom_range(0, 9) != 0);
      wr  = 1'($urandom_range(0, 1));
      tr  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) tr[1] = 1'b1;
      sz  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a   = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, NBYTES - 1));
      if (($urandom_range(0, 3) != 0) && (sz <= 3'd2)) a = a & ~((32'd1 << sz) - 32'd1);
      issue("rand", sel, tr, wr, sz, a, $urandom);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int          cyc;
    bit          bad_data;
    bit          bad_resp;
    logic [31:0] seen_data;
    cyc = 0; bad_data = 0; bad_resp = 0; seen_data = 32'h0;
    forever begin
      @(negedge HCLK);
      if (HRESET_n !== 1'b1 || exp_q.size() == 0) begin
        cyc = 0; bad_data = 0; bad_resp = 0;
        continue;
      end
      cyc++;
      if (HRESP !== exp_q[0].resp) bad_resp = 1;
      if (!bad_data) seen_data = HRDATA;
      if (HRDATA !== exp_q[0].rdata) bad_data = 1;
      if (HREADYOUT === 1'b1 || cyc > 40) begin
        checks++;
        txn_no++;
        if (!bad_data && !bad_resp && (cyc - 1) == exp_q[0].waits) begin
          passes++;
          $display("txn %0d %s: waits=%0d resp=%0b rdata=%h ok", txn_no, exp_q[0].tag,
                   cyc - 1, exp_q[0].resp, seen_data);
        end else begin
          $display("FAIL txn %0d %s: waits=%0d resp_wrong=%0b rdata=%h, required waits=%0d resp=%0b rdata=%h",
                   txn_no, exp_q[0].tag, cyc - 1, bad_resp, seen_data,
                   exp_q[0].waits, exp_q[0].resp, exp_q[0].rdata);
        end
        void'(exp_q.pop_front());
        cyc = 0; bad_data = 0; bad_resp = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int n;
    HRESET_n = 1'b0;
    HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b000; HBURST = 3'b000; HWDATA = 32'h0;
    repeat (3) @(negedge HCLK);
    check("reset_hready", 32'(HREADYOUT), 32'd1);
    check("reset_hresp",  32'(HRESP),     32'd0);
    check("reset_hrdata", HRDATA,         32'h0);
    @(posedge HCLK);
    #1;
    HRESET_n = 1'b1;

    // Give every word a known value.
    for (int w = 0; w < (1 << MEM_AW); w++)
      issue("fill", 1'b1, 2'b10, 1'b1, 3'b010, 32'(w * 4), $urandom);

    // Word write then back-to-back read.
    issue("wr_word", 1'b1, 2'b10, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    issue("rd_word", 1'b1, 2'b10, 1'b0, 3'b010, 32'h10, 32'h0);

    // Byte write into a known word.
    issue("wr_word", 1'b1, 2'b10, 1'b1, 3'b010, 32'h10, 32'h11223344);
    issue("wr_byte", 1'b1, 2'b10, 1'b1, 3'b000, 32'h13, 32'h5AA5A5A5);
    issue("idle",    1'b1, 2'b00, 1'b0, 3'b010, 32'h10, 32'h0);
    issue("rd_byte", 1'b1, 2'b10, 1'b0, 3'b010, 32'h10, 32'h0);
    issue("wr_half", 1'b1, 2'b10, 1'b1, 3'b001, 32'h16, 32'hBEEF0000);
    issue("rd_half", 1'b1, 2'b10, 1'b0, 3'b001, 32'h14, 32'h0);

    // INCR4 write and read-back.
    for (int b = 0; b < 4; b++)
      issue("incr4_wr", 1'b1, (b == 0) ? 2'b10 : 2'b11, 1'b1, 3'b010, 32'(32'h20 + 4*b), 32'(b + 1));
    for (int b = 0; b < 4; b++)
      issue("incr4_rd", 1'b1, (b == 0) ? 2'b10 : 2'b11, 1'b0, 3'b010, 32'(32'h20 + 4*b), 32'h0);

    // Illegal accesses, then confirm memory untouched.
    issue("err_range", 1'b1, 2'b10, 1'b1, 3'b010, 32'h400, 32'hFFFFFFFF);
    issue("err_align", 1'b1, 2'b10, 1'b0, 3'b010, 32'h02, 32'h0);
    issue("err_alignw",1'b1, 2'b10, 1'b1, 3'b010, 32'h02, 32'h0BADF00D);
    issue("err_half",  1'b1, 2'b10, 1'b1, 3'b001, 32'h01, 32'h0BADF00D);
    issue("err_size",  1'b1, 2'b10, 1'b1, 3'b011, 32'h00, 32'h0BADF00D);
    issue("rd_after_err", 1'b1, 2'b10, 1'b0, 3'b010, 32'h00, 32'h0);
    issue("rd_after_err", 1'b1, 2'b10, 1'b0, 3'b010, 32'h3FC, 32'h0);

    // Unselected and BUSY cycles are zero-wait OKAY with no access.
    issue("unsel", 1'b0, 2'b10, 1'b1, 3'b010, 32'h10, 32'hFFFFFFFF);
    issue("busy",  1'b1, 2'b01, 1'b1, 3'b010, 32'h10, 32'hFFFFFFFF);
    issue("rd_chk", 1'b1, 2'b10, 1'b0, 3'b010, 32'h10, 32'h0);

    // Reset during a waited write, then during a waited read.
    issue("idle", 1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0);
    reset_mid("rst_wr", 1'b1, 32'h40, 32'hCAFEF00D);
    issue("rd_after_rst", 1'b1, 2'b10, 1'b0, 3'b010, 32'h40, 32'h0);
    issue("idle", 1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0);
    reset_mid("rst_rd", 1'b0, 32'h10, 32'h0);

    random_phase(300);
    for (int w = 0; w < 16; w++)
      issue("final_rd", 1'b1, 2'b10, 1'b0, 3'b010, 32'($urandom_range(0, (1 << MEM_AW) - 1) * 4), 32'h0);
    issue("idle", 1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d phases still outstanding, required 0", exp_q.size());
    end
    @(posedge HCLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
